// File: rtl/t0_pkg.sv
// Shared types and constants for the ISO7816-3 T=0 TPDU master.
package t0_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PROC,
    TXDATA,
    RXDATA,
    SW2,
    DONE
  } t0State_e;

  localparam logic [7:0] PROC_NULL = 8'h60;
  localparam logic [7:0] SW1_LO_A  = 8'h61;
  localparam logic [7:0] SW1_HI_A  = 8'h6F;
  localparam logic [7:0] SW1_LO_B  = 8'h90;
  localparam logic [7:0] SW1_HI_B  = 8'h9F;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_PROC    = 2'd2;

  function automatic logic isSw1(input logic [7:0] b);
    return ((b >= SW1_LO_A) && (b <= SW1_HI_A)) || ((b >= SW1_LO_B) && (b <= SW1_HI_B));
  endfunction

endpackage

// File: rtl/t0_wait_timer.sv
// Work-waiting-time down-counter: reload sets WAIT_CYCLES, expired flags
// WAIT_CYCLES enabled cycles with no reload. A reload masks expiry.
module t0_wait_timer #(
  parameter int unsigned WAIT_CYCLES = 3571200,
  parameter int unsigned TMR_W       = 22
) (
  input  logic isoClk,
  input  logic isoReset,
  input  logic reload,
  input  logic enable,
  output logic expired
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge isoClk or negedge isoReset) begin
    if (!isoReset) begin
      count <= '0;
    end else if (reload) begin
      count <= TMR_W'(WAIT_CYCLES);
    end else if (enable && (count != '0)) begin
      count <= count - TMR_W'(1);
    end
  end

  assign expired = enable && !reload && (count == '0);

endmodule

// File: rtl/t0_tpdu_master.sv
// Reader-side T=0 TPDU engine: header, procedure bytes, data phase, SW1/SW2.
// Optional macro T0_PROC_ACK_INV_EN enables single-byte transfers on ~INS.
module t0_tpdu_master
  import t0_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3571200,
  parameter int unsigned TMR_W       = 22
) (
  input  logic       isoClk,
  input  logic       isoReset,
  input  logic       start,
  input  logic [7:0] cla,
  input  logic [7:0] ins,
  input  logic [7:0] p1,
  input  logic [7:0] p2,
  input  logic [7:0] p3,
  input  logic       isWrite,
  input  logic [7:0] wrData,
  input  logic       wrValid,
  output logic       wrReady,
  output logic [7:0] rdData,
  output logic       rdValid,
  output logic [7:0] sw1,
  output logic [7:0] sw2,
  output logic       busy,
  output logic       done,
  output logic [1:0] errCode,
  output logic [7:0] uartTxData,
  output logic       uartTxValid,
  input  logic       uartTxReady,
  input  logic [7:0] uartRxData,
  input  logic       uartRxValid
);

  t0State_e state, stateNext;

  logic [4:0][7:0] hdr;
  logic [2:0]      hdrIdx;
  logic            isWr;
  logic [8:0]      remaining;
  logic            single;

  logic       ldHdr, hdrAdv, remDec, sw1Ld, sw2Ld, rdLd, singleSet, errLd, txXfer;
  logic [1:0] errNext;
  logic       tmrEn, tmrReload, tmrExpired;

  // The timer only counts while waiting on the card; any other state holds it loaded.
  assign tmrEn     = (state == PROC) || (state == RXDATA) || (state == SW2);
  assign tmrReload = !tmrEn || uartRxValid;

  t0_wait_timer #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .TMR_W      (TMR_W)
  ) uTimer (
    .isoClk  (isoClk),
    .isoReset(isoReset),
    .reload  (tmrReload),
    .enable  (tmrEn),
    .expired (tmrExpired)
  );

  always_ff @(posedge isoClk or negedge isoReset) begin
    if (!isoReset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext   = state;
    ldHdr       = 1'b0;
    hdrAdv      = 1'b0;
    remDec      = 1'b0;
    sw1Ld       = 1'b0;
    sw2Ld       = 1'b0;
    rdLd        = 1'b0;
    singleSet   = 1'b0;
    errLd       = 1'b0;
    errNext     = ERR_NONE;
    txXfer      = 1'b0;
    uartTxData  = '0;
    uartTxValid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          ldHdr     = 1'b1;
          stateNext = HDR;
        end
      end
      HDR: begin
        uartTxData  = hdr[hdrIdx];
        uartTxValid = 1'b1;
        if (uartTxReady) begin
          hdrAdv = 1'b1;
          if (hdrIdx == 3'd4) stateNext = PROC;
        end
      end
      PROC: begin
        if (uartRxValid) begin
          if (uartRxData == PROC_NULL) begin
            stateNext = PROC;
          end else if (uartRxData == hdr[1]) begin
            if (remaining != '0) stateNext = isWr ? TXDATA : RXDATA;
`ifdef T0_PROC_ACK_INV_EN
          end else if (uartRxData == ~hdr[1]) begin
            if (remaining != '0) begin
              singleSet = 1'b1;
              stateNext = isWr ? TXDATA : RXDATA;
            end else begin
              errLd     = 1'b1;
              errNext   = ERR_PROC;
              stateNext = DONE;
            end
`endif
          end else if (isSw1(uartRxData)) begin
            sw1Ld     = 1'b1;
            stateNext = SW2;
          end else begin
            errLd     = 1'b1;
            errNext   = ERR_PROC;
            stateNext = DONE;
          end
        end else if (tmrExpired) begin
          errLd     = 1'b1;
          errNext   = ERR_TIMEOUT;
          stateNext = DONE;
        end
      end
      TXDATA: begin
        uartTxData  = wrData;
        uartTxValid = wrValid;
        txXfer      = uartTxReady && wrValid;
        if (txXfer) begin
          remDec = 1'b1;
          if (single || (remaining == 9'd1)) stateNext = PROC;
        end
      end
      RXDATA: begin
        if (uartRxValid) begin
          rdLd   = 1'b1;
          remDec = 1'b1;
          if (single || (remaining == 9'd1)) stateNext = PROC;
        end else if (tmrExpired) begin
          errLd     = 1'b1;
          errNext   = ERR_TIMEOUT;
          stateNext = DONE;
        end
      end
      SW2: begin
        if (uartRxValid) begin
          sw2Ld     = 1'b1;
          stateNext = DONE;
        end else if (tmrExpired) begin
          errLd     = 1'b1;
          errNext   = ERR_TIMEOUT;
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign wrReady = txXfer;
  assign done    = (state == DONE);
  assign busy    = (state != IDLE) && (state != DONE);

  always_ff @(posedge isoClk or negedge isoReset) begin
    if (!isoReset) begin
      hdr       <= '0;
      hdrIdx    <= '0;
      isWr      <= 1'b0;
      remaining <= '0;
      single    <= 1'b0;
      sw1       <= '0;
      sw2       <= '0;
      errCode   <= ERR_NONE;
      rdData    <= '0;
      rdValid   <= 1'b0;
    end else begin
      rdValid <= rdLd;
      if (ldHdr) begin
        hdr       <= {p3, p2, p1, ins, cla};
        hdrIdx    <= '0;
        isWr      <= isWrite;
        remaining <= ((p3 == 8'h00) && !isWrite) ? 9'd256 : {1'b0, p3};
        sw1       <= '0;
        sw2       <= '0;
        errCode   <= ERR_NONE;
      end
      if (hdrAdv) hdrIdx <= hdrIdx + 3'd1;
      if (remDec) remaining <= remaining - 9'd1;
      // Single-byte mode is decided by the procedure byte that leaves PROC.
      if (state == PROC) single <= singleSet;
      if (sw1Ld) sw1 <= uartRxData;
      if (sw2Ld) sw2 <= uartRxData;
      if (rdLd) rdData <= uartRxData;
      if (errLd) errCode <= errNext;
    end
  end

endmodule

// File: tb/tb_t0_tpdu_master.sv
// Self-checking bench for t0_tpdu_master: a scripted card drives the UART side,
// expectations come from the TPDU rules. Honours T0_PROC_ACK_INV_EN.
`timescale 1ns/1ps
module tb_t0_tpdu_master;

  localparam int unsigned W = 400;
  localparam int unsigned NW = (W * 8) / 10;

  logic       isoClk = 1'b0, isoReset = 1'b0;
  logic       start = 1'b0, isWrite = 1'b0, wrValid = 1'b0, uartTxReady = 1'b0, uartRxValid = 1'b0;
  logic [7:0] cla = '0, ins = '0, p1 = '0, p2 = '0, p3 = '0, wrData = '0, uartRxData = '0;
  logic       wrReady, rdValid, busy, done, uartTxValid;
  logic [7:0] rdData, sw1, sw2, uartTxData;
  logic [1:0] errCode;

  t0_tpdu_master #(.WAIT_CYCLES(W), .TMR_W(22)) dut (
    .isoClk(isoClk), .isoReset(isoReset), .start(start),
    .cla(cla), .ins(ins), .p1(p1), .p2(p2), .p3(p3), .isWrite(isWrite),
    .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady),
    .rdData(rdData), .rdValid(rdValid), .sw1(sw1), .sw2(sw2),
    .busy(busy), .done(done), .errCode(errCode),
    .uartTxData(uartTxData), .uartTxValid(uartTxValid), .uartTxReady(uartTxReady),
    .uartRxData(uartRxData), .uartRxValid(uartRxValid)
  );

  always #5 isoClk = ~isoClk;

  int vectors = 0, miscompares = 0;

  // Card script: byte b is sent once waitTx bytes have left the reader, after delay cycles.
  logic [7:0] scrB[$];
  int         scrWait[$], scrDelay[$];
  logic [7:0] wrBuf[$], txLog[$], rdLog[$], expTx[$], expRd[$];
  int         doneCnt, doneCyc, hdrEnd, abortRd, restartAt;
  bit         randReady, busyAt1, busyAtDone, abortBusy, abortTxValid, abortDone;
  logic [7:0] capSw1, capSw2;
  logic [1:0] capErr;

  task automatic newScenario();
    scrB.delete(); scrWait.delete(); scrDelay.delete(); wrBuf.delete();
    expTx.delete(); expRd.delete();
    randReady = 1'b0; abortRd = -1; restartAt = -1;
  endtask

  task automatic addB(input logic [7:0] b, input int waitTx, input int delay);
    scrB.push_back(b); scrWait.push_back(waitTx); scrDelay.push_back(delay);
  endtask

  task automatic runTpdu(input logic [7:0] c, input logic [7:0] i, input logic [7:0] len,
                         input bit wr, input int budget);
    int si = 0, dly = 0, wrIdx = 0, post = 0;
    logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    txLog.delete(); rdLog.delete();
    doneCnt = 0; doneCyc = -1; hdrEnd = -1; busyAt1 = 1'b0; busyAtDone = 1'b1;
    capSw1 = '0; capSw2 = '0; capErr = '0;
    abortBusy = 1'b1; abortTxValid = 1'b1; abortDone = 1'b1;
    cla = c; ins = i; p1 = a; p2 = b; p3 = len; isWrite = wr;
    expTx.push_back(c); expTx.push_back(i); expTx.push_back(a); expTx.push_back(b); expTx.push_back(len);
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge isoClk);
      if (abortRd >= 0 && rdLog.size() == abortRd) begin
        isoReset = 1'b0;
        #1;
        abortBusy = busy; abortTxValid = uartTxValid; abortDone = done;
        @(negedge isoClk);
        isoReset = 1'b1; start = 1'b0; uartRxValid = 1'b0; wrValid = 1'b0;
        return;
      end
      start = (cyc == 0) || (cyc == restartAt);
      if (cyc == restartAt) begin
        cla = 8'($urandom); ins = 8'($urandom); p3 = 8'($urandom); isWrite = ~wr;
      end
      uartRxValid = 1'b0;
      if (si < scrB.size() && txLog.size() >= scrWait[si]) begin
        if (dly >= scrDelay[si]) begin
          uartRxValid = 1'b1; uartRxData = scrB[si]; si++; dly = 0;
        end else dly++;
      end
      uartTxReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      wrValid = (wrIdx < wrBuf.size()) && ($urandom_range(0, 3) != 0);
      wrData = (wrIdx < wrBuf.size()) ? wrBuf[wrIdx] : 8'($urandom);
      #1;
      if (cyc == 1) busyAt1 = busy;
      if (uartTxValid && uartTxReady) begin
        txLog.push_back(uartTxData);
        if (txLog.size() == 5) hdrEnd = cyc;
      end
      if (wrReady) wrIdx++;
      if (rdValid) rdLog.push_back(rdData);
      if (done) begin
        doneCnt++; doneCyc = cyc; capSw1 = sw1; capSw2 = sw2; capErr = errCode; busyAtDone = busy;
      end
      if (doneCnt > 0) begin
        post++;
        if (post > 4) break;
      end
    end
    start = 1'b0; uartRxValid = 1'b0; wrValid = 1'b0;
  endtask

  function automatic logic [7:0] stWord();
    return {4'(doneCnt), capErr, busyAt1, busyAtDone};
  endfunction

  task automatic test_reset();
    logic [41:0] got;
    wrValid = 1'b1; uartTxReady = 1'b1; uartRxValid = 1'b1; uartRxData = 8'h90; start = 1'b1;
    repeat (3) @(negedge isoClk);
    #1;
    got = {busy, done, rdValid, uartTxValid, wrReady, sw1, sw2, errCode, rdData, uartTxData};
    vectors++;
    if (got !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got %h expected 0", got);
    end
    start = 1'b0; wrValid = 1'b0; uartRxValid = 1'b0;
    @(negedge isoClk);
    isoReset = 1'b1;
    repeat (2) @(negedge isoClk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_write(input bit fixed);
    int n;
    logic [7:0] c;
    newScenario();
    n = fixed ? 3 : $urandom_range(1, 6);
    c = fixed ? 8'h00 : 8'($urandom);
    randReady = !fixed;
    for (int k = 0; k < n; k++) wrBuf.push_back(fixed ? 8'(8'h11 * (k + 1)) : 8'($urandom));
    addB(8'h61, 2, 0);                              // echo during header, must be dropped
    addB(8'h0C, 5, $urandom_range(0, 5));
    if (n >= 2) addB(8'h90, 6, 0);                  // echo during data phase
    addB(8'h90, 5 + n, $urandom_range(0, 5));
    addB(8'h00, 5 + n, $urandom_range(0, 5));
    runTpdu(c, 8'h0C, 8'(n), 1'b1, 2000);
    foreach (wrBuf[k]) expTx.push_back(wrBuf[k]);
    vectors++;
    if (stWord() !== {4'd1, 2'd0, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL write_status: got %h expected %h", stWord(), {4'd1, 2'd0, 1'b1, 1'b0});
    end
    vectors++;
    if ({capSw1, capSw2} !== 16'h9000) begin
      miscompares++; $display("FAIL write_sw: got %h expected 9000", {capSw1, capSw2});
    end
    vectors++;
    if (txLog.size() != expTx.size() || rdLog.size() != 0) begin
      miscompares++; $display("FAIL write_counts: got tx %0d rd %0d expected tx %0d rd 0", txLog.size(), rdLog.size(), expTx.size());
    end
    for (int k = 0; k < expTx.size() && k < txLog.size(); k++) begin
      vectors++;
      if (txLog[k] !== expTx[k]) begin
        miscompares++; $display("FAIL write_tx[%0d]: got %h expected %h", k, txLog[k], expTx[k]);
      end
    end
  endtask

  task automatic test_read(input logic [7:0] len, input bit fixed);
    int n;
    newScenario();
    n = (len == 8'h00) ? 256 : int'(len);
    randReady = !fixed;
    for (int k = 0; k < n; k++) expRd.push_back(fixed ? 8'(8'h11 * (k + 1)) : 8'($urandom));
    addB(8'h0A, 5, $urandom_range(0, 3));
    foreach (expRd[k]) addB(expRd[k], 5, $urandom_range(0, 2));
    addB(8'h90, 5, $urandom_range(0, 3));
    addB(8'h00, 5, $urandom_range(0, 3));
    runTpdu(8'h00, 8'h0A, len, 1'b0, 4000);
    vectors++;
    if (stWord() !== {4'd1, 2'd0, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL read_status: got %h expected %h", stWord(), {4'd1, 2'd0, 1'b1, 1'b0});
    end
    vectors++;
    if ({capSw1, capSw2} !== 16'h9000 || txLog.size() != 5) begin
      miscompares++; $display("FAIL read_sw_tx: got sw %h tx %0d expected sw 9000 tx 5", {capSw1, capSw2}, txLog.size());
    end
    vectors++;
    if (rdLog.size() != expRd.size()) begin
      miscompares++; $display("FAIL read_count: got %0d expected %0d", rdLog.size(), expRd.size());
    end
    for (int k = 0; k < expRd.size() && k < rdLog.size(); k++) begin
      vectors++;
      if (rdLog[k] !== expRd[k]) begin
        miscompares++; $display("FAIL read_rd[%0d]: got %h expected %h", k, rdLog[k], expRd[k]);
      end
    end
  endtask

  task automatic test_unknown_ins();
    newScenario();
    restartAt = 3;                                  // start while busy must be ignored
    addB(8'h69, 5, $urandom_range(0, 10));
    addB(8'h86, 5, $urandom_range(0, 10));
    runTpdu(8'h00, 8'hB0, 8'h04, 1'b0, 1000);
    vectors++;
    if (stWord() !== {4'd1, 2'd0, 1'b1, 1'b0} || {capSw1, capSw2} !== 16'h6986) begin
      miscompares++; $display("FAIL unknown_ins_status: got %h/%h expected %h/6986", stWord(), {capSw1, capSw2}, {4'd1, 2'd0, 1'b1, 1'b0});
    end
    vectors++;
    if (txLog.size() != 5 || rdLog.size() != 0) begin
      miscompares++; $display("FAIL unknown_ins_counts: got tx %0d rd %0d expected tx 5 rd 0", txLog.size(), rdLog.size());
    end
    for (int k = 0; k < 5 && k < txLog.size(); k++) begin
      vectors++;
      if (txLog[k] !== expTx[k]) begin
        miscompares++; $display("FAIL unknown_ins_tx[%0d]: got %h expected %h", k, txLog[k], expTx[k]);
      end
    end
  endtask

  task automatic test_null_wait();
    logic [7:0] d;
    newScenario();
    d = 8'($urandom);
    addB(8'h60, 5, NW); addB(8'h60, 5, NW); addB(8'h0A, 5, NW);
    addB(d, 5, NW); addB(8'h91, 5, NW); addB(8'h23, 5, NW);
    runTpdu(8'h00, 8'h0A, 8'h01, 1'b0, 4000);
    vectors++;
    if (stWord() !== {4'd1, 2'd0, 1'b1, 1'b0} || {capSw1, capSw2} !== 16'h9123) begin
      miscompares++; $display("FAIL null_status: got %h/%h expected %h/9123", stWord(), {capSw1, capSw2}, {4'd1, 2'd0, 1'b1, 1'b0});
    end
    vectors++;
    if (rdLog.size() != 1 || (rdLog.size() == 1 && rdLog[0] !== d)) begin
      miscompares++; $display("FAIL null_rd: got %0d bytes first %h expected 1 byte %h", rdLog.size(), (rdLog.size() > 0) ? rdLog[0] : 8'h00, d);
    end
  endtask

  task automatic test_timeout();
    int dt;
    newScenario();
    runTpdu(8'h00, 8'h0A, 8'h02, 1'b0, 2 * W);
    dt = doneCyc - hdrEnd;
    vectors++;
    if (stWord() !== {4'd1, 2'd1, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL timeout_proc_status: got %h expected %h", stWord(), {4'd1, 2'd1, 1'b1, 1'b0});
    end
    vectors++;
    if (dt < int'(W) + 1 || dt > int'(W) + 3) begin
      miscompares++; $display("FAIL timeout_proc_latency: got %0d expected %0d..%0d", dt, W + 1, W + 3);
    end
    newScenario();
    addB(8'h0A, 5, 2); addB(8'h5A, 5, 3);
    runTpdu(8'h00, 8'h0A, 8'h03, 1'b0, 2 * W);
    vectors++;
    if (stWord() !== {4'd1, 2'd1, 1'b1, 1'b0} || rdLog.size() != 1) begin
      miscompares++; $display("FAIL timeout_rx: got %h rd %0d expected %h rd 1", stWord(), rdLog.size(), {4'd1, 2'd1, 1'b1, 1'b0});
    end
    newScenario();
    addB(8'h62, 5, 1);
    runTpdu(8'h00, 8'h0A, 8'h03, 1'b0, 2 * W);
    vectors++;
    if (stWord() !== {4'd1, 2'd1, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL timeout_sw2: got %h expected %h", stWord(), {4'd1, 2'd1, 1'b1, 1'b0});
    end
  endtask

  task automatic test_bad_proc();
    newScenario();
    wrBuf.push_back(8'hA5); wrBuf.push_back(8'h5A);
    addB(8'h42, 5, $urandom_range(0, 20));
    runTpdu(8'h00, 8'hD6, 8'h02, 1'b1, 1000);
    vectors++;
    if (stWord() !== {4'd1, 2'd2, 1'b1, 1'b0} || txLog.size() != 5) begin
      miscompares++; $display("FAIL bad_proc: got %h tx %0d expected %h tx 5", stWord(), txLog.size(), {4'd1, 2'd2, 1'b1, 1'b0});
    end
  endtask

  task automatic test_inv_ack();
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    newScenario();
    addB(8'hF5, 5, 3); addB(b1, 5, 2); addB(8'hF5, 5, 4); addB(b2, 5, 1);
    addB(8'h90, 5, 2); addB(8'h00, 5, 2);
    runTpdu(8'h00, 8'h0A, 8'h02, 1'b0, 1000);
`ifdef T0_PROC_ACK_INV_EN
    vectors++;
    if (stWord() !== {4'd1, 2'd0, 1'b1, 1'b0} || rdLog.size() != 2 || (rdLog.size() == 2 && {rdLog[0], rdLog[1]} !== {b1, b2})) begin
      miscompares++; $display("FAIL inv_ack_rx: got %h rd %0d expected %h rd %h%h", stWord(), rdLog.size(), {4'd1, 2'd0, 1'b1, 1'b0}, b1, b2);
    end
    newScenario();
    wrBuf.push_back(b1); wrBuf.push_back(b2);
    addB(8'hCE, 5, 2); addB(8'hCE, 6, 2); addB(8'h90, 7, 2); addB(8'h00, 7, 2);
    runTpdu(8'h00, 8'h31, 8'h02, 1'b1, 1000);
    vectors++;
    if (stWord() !== {4'd1, 2'd0, 1'b1, 1'b0} || txLog.size() != 7 || (txLog.size() == 7 && {txLog[5], txLog[6]} !== {b1, b2})) begin
      miscompares++; $display("FAIL inv_ack_tx: got %h tx %0d expected %h tx 7", stWord(), txLog.size(), {4'd1, 2'd0, 1'b1, 1'b0});
    end
    newScenario();
    addB(8'hF5, 5, 1); addB(b1, 5, 1); addB(8'hF5, 5, 1);
    runTpdu(8'h00, 8'h0A, 8'h01, 1'b0, 1000);
    vectors++;
    if (stWord() !== {4'd1, 2'd2, 1'b1, 1'b0} || rdLog.size() != 1) begin
      miscompares++; $display("FAIL inv_ack_exhausted: got %h rd %0d expected %h rd 1", stWord(), rdLog.size(), {4'd1, 2'd2, 1'b1, 1'b0});
    end
`else
    vectors++;
    if (stWord() !== {4'd1, 2'd2, 1'b1, 1'b0} || rdLog.size() != 0) begin
      miscompares++; $display("FAIL inv_ack_disabled: got %h rd %0d expected %h rd 0", stWord(), rdLog.size(), {4'd1, 2'd2, 1'b1, 1'b0});
    end
`endif
  endtask

  task automatic test_reset_mid_rx();
    newScenario();
    abortRd = 2;
    addB(8'h0A, 5, 1);
    for (int k = 0; k < 4; k++) addB(8'($urandom), 5, 2);
    addB(8'h90, 5, 1); addB(8'h00, 5, 1);
    runTpdu(8'h00, 8'h0A, 8'h04, 1'b0, 1000);
    vectors++;
    if ({abortBusy, abortTxValid, abortDone} !== 3'b000 || doneCnt != 0) begin
      miscompares++; $display("FAIL reset_mid_rx: got busy/txv/done %b%b%b pulses %0d expected 000 pulses 0", abortBusy, abortTxValid, abortDone, doneCnt);
    end
    test_read(8'h03, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write(1'b1);
    test_write(1'b0);
    test_read(8'h02, 1'b1);
    test_read(8'h00, 1'b0);
    test_read(8'($urandom_range(1, 20)), 1'b0);
    test_unknown_ins();
    test_null_wait();
    test_timeout();
    test_bad_proc();
    test_inv_ack();
    test_reset_mid_rx();
    test_write(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
